cpu_datapath: RTL
=================

CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data width of all registers and the bus.
REQ-002 SHALL have parameter AW, default 8, meaning memory address width (MAR width).
REQ-003 SHALL have parameter SP_RST, default 8'hFF, meaning SP reset value.
REQ-004 SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports PC_i, IR_i, MAR_i, MDR_i, ACC_i, SP_i, R_i  input  1 each  register load enables from the control unit.
REQ-007 SHALL have ports PC_o, MDR_o, ACC_o, SP_o, R_o  input  1 each  internal bus drive enables.
REQ-008 SHALL have ports PC_Sel, MDR_Sel, ACC_Sel, ALU_Sel  input  1 each  source and operation selects.
REQ-009 SHALL have ports MemRead, MemWrite  input  1 each  memory strobes.
REQ-010 SHALL have port IR  output  8  instruction register, feeding the control unit.
REQ-011 SHALL have port ZF  output  1  zero flag, feeding the control unit.
REQ-012 SHALL have ports mem_addr  output  AW  = MAR;  mem_wdata  output  DW  = MDR;  mem_rd  output  1;  mem_we  output  1.
REQ-013 SHALL have port mem_rdata  input  DW  combinational read data, valid in the same cycle mem_rd is high.

Function
REQ-014 The bus SHALL be combinational, with source priority PC_o > MDR_o > ACC_o > SP_o > R_o and value 0 when no source is enabled.
REQ-015 All register updates SHALL occur on rising clk, one cycle after their enable is sampled high, and registers SHALL hold their value when not enabled.
REQ-016 When PC_i=1, PC SHALL load the bus if PC_Sel=1, else PC+1 mod 2^DW.
REQ-017 When IR_i=1, IR SHALL load the bus; when MAR_i=1, MAR SHALL load bus[AW-1:0]; when SP_i=1, SP SHALL load the bus; when R_i=1, R SHALL load the bus.
REQ-018 When MDR_i=1, MDR SHALL load mem_rdata if MDR_Sel=1, else the bus.
REQ-019 The alu sub-block SHALL compute ACC+bus mod 2^DW with carry discarded when ALU_Sel=0, and ACC&bus when ALU_Sel=1.
REQ-020 When ACC_i=1, ACC SHALL load the ALU result if ACC_Sel=1, else the bus.
REQ-021 ZF SHALL be updated only on an ACC load, to (new ACC value == 0), and SHALL hold otherwise.
REQ-022 mem_rd SHALL equal MemRead & ~MemWrite, and mem_we SHALL equal MemWrite, both combinational.
REQ-023 If MemRead and MemWrite are both high, the write SHALL win and the read SHALL be suppressed.
REQ-024 A register that is both the bus source and the load target in the same cycle SHALL capture its own pre-edge value; for PC with PC_Sel=0 it SHALL capture the incremented value.
REQ-025 On PC increment from all-ones, PC SHALL wrap to 0.

Reset
REQ-026 While reset=1, PC, IR, MAR, MDR, ACC, R SHALL be 0, SP SHALL be SP_RST, and ZF SHALL be 1, independent of clk.
REQ-027 A reset asserted mid-operation SHALL discard any pending load, and after release the first edge SHALL obey the enables then present.
REQ-028 mem_rd and mem_we SHALL follow MemRead and MemWrite combinationally during reset, so that no extra gating is applied.

Structure
REQ-029 A shared package SHALL hold DW and AW defaults, SP_RST, ALU op encodings (ALU_ADD=0, ALU_AND=1) and the select encodings for PC_Sel, MDR_Sel and ACC_Sel.
REQ-030 The ALU SHALL be a separate combinational sub-module named dp_alu, and the bus mux and registers SHALL remain in cpu_datapath.

Verification
REQ-031 Reset: with reset=1 mid-cycle and no clk -> PC=0, SP=FF, ZF=1 immediately.
REQ-032 Fetch: PC=05, PC_o+MAR_i, then MemRead+MDR_i+MDR_Sel=1 with mem_rdata=A3, then MDR_o+IR_i, then PC_i with PC_Sel=0 -> MAR=05, IR=A3, PC=06.
REQ-033 ALU: ACC=F0, R=20, R_o+ACC_i+ACC_Sel=1+ALU_Sel=0 -> ACC=10, ZF=0; then ACC=0F with R=F0 and ALU_Sel=1 -> ACC=00, ZF=1.
REQ-034 Bus priority: PC=11, ACC=22, PC_o+ACC_o+R_i -> R=11; then no _o with R_i -> R=00.
REQ-035 Memory: MemRead=MemWrite=1 with MAR=40, MDR=5A -> mem_we=1, mem_rd=0, mem_addr=40, mem_wdata=5A.
REQ-036 Wrap: PC=FF, PC_i with PC_Sel=0 -> PC=00, and ZF shall be unchanged.

Source files
------------

// File: rtl/cpu_datapath_pkg.sv
// Shared widths, reset values and select encodings for the accumulator datapath.
package cpu_datapath_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned AW_DEF = 8;
  localparam logic [7:0]  SP_RST_DEF = 8'hFF;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_AND = 1'b1;

  localparam logic PC_SEL_INC  = 1'b0;
  localparam logic PC_SEL_BUS  = 1'b1;
  localparam logic MDR_SEL_BUS = 1'b0;
  localparam logic MDR_SEL_MEM = 1'b1;
  localparam logic ACC_SEL_BUS = 1'b0;
  localparam logic ACC_SEL_ALU = 1'b1;

endpackage

// File: rtl/cpu_datapath_if.sv
// Memory port of the datapath: address/write data out, combinational read data in.
interface cpu_datapath_if #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 8
);
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_rd;
   logic          mem_we;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_rd,
      output mem_we,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_rd,
      input  mem_we,
      output mem_rdata
   );
endinterface

// File: rtl/dp_alu.sv
// Combinational ALU: wrapping add or bitwise AND of accumulator and bus.
module dp_alu
   import cpu_datapath_pkg::*;
#(
   parameter int unsigned DW = DW_DEF
) (
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   input  logic          op_i,
   output logic [DW-1:0] y_o
);

   always_comb begin
      y_o = '0;
      unique case (op_i)
         ALU_ADD: y_o = a_i + b_i;
         ALU_AND: y_o = a_i & b_i;
      endcase
   end

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus accumulator datapath: priority bus mux, register file with load enables,
// ALU, zero flag and memory strobes.
module cpu_datapath
   import cpu_datapath_pkg::*;
#(
   parameter int unsigned   DW     = DW_DEF,
   parameter int unsigned   AW     = AW_DEF,
   parameter logic [DW-1:0] SP_RST = DW'(SP_RST_DEF)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               PC_i,
   input  logic               IR_i,
   input  logic               MAR_i,
   input  logic               MDR_i,
   input  logic               ACC_i,
   input  logic               SP_i,
   input  logic               R_i,
   input  logic               PC_o,
   input  logic               MDR_o,
   input  logic               ACC_o,
   input  logic               SP_o,
   input  logic               R_o,
   input  logic               PC_Sel,
   input  logic               MDR_Sel,
   input  logic               ACC_Sel,
   input  logic               ALU_Sel,
   input  logic               MemRead,
   input  logic               MemWrite,
   output logic [7:0]         IR,
   output logic               ZF,
   cpu_datapath_if.master     mem
);

   logic [DW-1:0] pc_q, mdr_q, acc_q, sp_q, r_q;
   logic [7:0]    ir_q;
   logic [AW-1:0] mar_q;
   logic          zf_q;
   logic [DW-1:0] bus, alu_y, pc_d, mdr_d, acc_d;

   always_comb begin
      bus = '0;
      if (PC_o)       bus = pc_q;
      else if (MDR_o) bus = mdr_q;
      else if (ACC_o) bus = acc_q;
      else if (SP_o)  bus = sp_q;
      else if (R_o)   bus = r_q;
   end

   dp_alu #(
      .DW(DW)
   ) u_alu (
      .a_i (acc_q),
      .b_i (bus),
      .op_i(ALU_Sel),
      .y_o (alu_y)
   );

   always_comb begin
      pc_d  = pc_q;
      mdr_d = mdr_q;
      acc_d = acc_q;
      unique case (PC_Sel)
         PC_SEL_BUS: pc_d = bus;
         PC_SEL_INC: pc_d = pc_q + DW'(1);
      endcase
      unique case (MDR_Sel)
         MDR_SEL_MEM: mdr_d = mem.mem_rdata;
         MDR_SEL_BUS: mdr_d = bus;
      endcase
      unique case (ACC_Sel)
         ACC_SEL_ALU: acc_d = alu_y;
         ACC_SEL_BUS: acc_d = bus;
      endcase
   end

   // Bus is built from pre-edge values, so a register sourcing its own load keeps its value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= '0;
         ir_q  <= '0;
         mar_q <= '0;
         mdr_q <= '0;
         acc_q <= '0;
         sp_q  <= SP_RST;
         r_q   <= '0;
         zf_q  <= 1'b1;
      end else begin
         if (PC_i)  pc_q  <= pc_d;
         if (IR_i)  ir_q  <= bus[7:0];
         if (MAR_i) mar_q <= bus[AW-1:0];
         if (MDR_i) mdr_q <= mdr_d;
         if (SP_i)  sp_q  <= bus;
         if (R_i)   r_q   <= bus;
         if (ACC_i) begin
            acc_q <= acc_d;
            zf_q  <= (acc_d == '0);
         end
      end
   end

   assign IR            = ir_q;
   assign ZF            = zf_q;
   assign mem.mem_addr  = mar_q;
   assign mem.mem_wdata = mdr_q;
   // Write wins a read/write collision; strobes are deliberately not gated by reset.
   assign mem.mem_rd    = MemRead & ~MemWrite;
   assign mem.mem_we    = MemWrite;

endmodule
